cd_sector_fifo: RTL and testbench

- Byte buffer and sector-request sequencer directly downstream of the PCE CD SPI data_io stage.
- Accepts CD sector bytes (cd_data_out/cd_data_out_strobe/cd_dm), stores each byte with its mode tag, and presents them to the PCE CD-ROM interface through a pop handshake.
- Generates cd_dat_req to fetch sectors and cd_fifo_halffull as backpressure status for the IO controller.

---
 rtl/cd_sector_fifo.sv | 154 +++++++++++++++
 tb/tb_cd_sector_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_sector_fifo.sv
// Sector byte buffer between the CD SPI data stage and the CD-ROM interface,
// with a one-deep queued sector-request sequencer.
//
// state  | meaning
// S_IDLE | no sector in flight; waits for a request and a FIFO below half full
// S_REQ  | cd_dat_req pulse cycle; sector byte counter is armed
// S_RECV | counting strobes until the latched sector length is reached
module cd_sector_fifo #(
  parameter int AW        = 12,
  parameter int DATA_LEN  = 2048,
  parameter int AUDIO_LEN = 2352
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] cd_data_out,
  input  logic       cd_data_out_strobe,
  input  logic       cd_dm,
  input  logic       flush,
  input  logic       sector_req,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       dout_dm,
  output logic       dout_valid,
  output logic       cd_dat_req,
  output logic       cd_fifo_halffull,
  output logic       sector_done,
  output logic       busy,
  output logic       overflow
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   HALF_LVL = {2'b01, {(AW-1){1'b0}}};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV} state_t;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, wr_acc, load;

  state_t        state;
  logic          pending, first;
  logic [11:0]   rem;

  always_comb begin
    full   = (level == FULL_LVL);
    wr_acc = cd_data_out_strobe && !full && !flush && !reset;
    load   = !dout_valid && (level != '0) && !flush && !reset;
  end

  always_ff @(posedge clk_sys) begin
    if (wr_acc) mem[wr_ptr] <= {cd_dm, cd_data_out};
  end

  // The output register doubles as the RAM's registered read port.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      dout             <= '0;
      dout_dm          <= 1'b0;
      dout_valid       <= 1'b0;
      overflow         <= 1'b0;
      cd_fifo_halffull <= 1'b0;
    end else begin
      cd_fifo_halffull <= (level >= HALF_LVL);
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
        dout_valid <= 1'b0;
      end else begin
        if (cd_data_out_strobe && full) overflow <= 1'b1;
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (load) begin
          {dout_dm, dout} <= mem[rd_ptr];
          rd_ptr          <= rd_ptr + PTR_ONE;
          dout_valid      <= 1'b1;
        end else if (rd && dout_valid) begin
          dout_valid <= 1'b0;
        end
        case ({wr_acc, load})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: level <= level;
        endcase
      end
    end
  end

  // rem counts strobes still owed after the current one; the first strobe
  // of a sector picks the length from its mode tag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      first       <= 1'b0;
      rem         <= '0;
      cd_dat_req  <= 1'b0;
      sector_done <= 1'b0;
      busy        <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      cd_dat_req  <= 1'b0;
      sector_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cd_dat_req  <= 1'b0;
      sector_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if ((sector_req || pending) && !cd_fifo_halffull) begin
            state      <= S_REQ;
            pending    <= 1'b0;
            cd_dat_req <= 1'b1;
            busy       <= 1'b1;
          end else if (sector_req) begin
            pending <= 1'b1;
          end
        end
        S_REQ: begin
          if (sector_req) pending <= 1'b1;
          first <= 1'b1;
          state <= S_RECV;
        end
        S_RECV: begin
          if (sector_req) pending <= 1'b1;
          if (cd_data_out_strobe) begin
            if (first) begin
              first <= 1'b0;
              rem   <= cd_dm ? 12'(DATA_LEN - 2) : 12'(AUDIO_LEN - 2);
            end else if (rem == '0) begin
              sector_done <= 1'b1;
              state       <= S_IDLE;
              busy        <= 1'b0;
            end else begin
              rem <= rem - 12'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cd_sector_fifo.sv
// Bench for cd_sector_fifo: lockstep queue-based reference model plus directed
// checks of latency, sector boundaries, half-full backpressure, overflow and flush.
module tb_cd_sector_fifo;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cd_data_out = '0;
  logic       cd_data_out_strobe = 1'b0;
  logic       cd_dm = 1'b0;
  logic       flush = 1'b0;
  logic       sector_req = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       dout_dm, dout_valid, cd_dat_req, cd_fifo_halffull;
  logic       sector_done, busy, overflow;

  always #5 clk_sys = ~clk_sys;

  cd_sector_fifo #(.AW(12), .DATA_LEN(2048), .AUDIO_LEN(2352)) dut (
    .clk_sys(clk_sys), .reset(reset), .cd_data_out(cd_data_out),
    .cd_data_out_strobe(cd_data_out_strobe), .cd_dm(cd_dm), .flush(flush),
    .sector_req(sector_req), .rd(rd), .dout(dout), .dout_dm(dout_dm),
    .dout_valid(dout_valid), .cd_dat_req(cd_dat_req),
    .cd_fifo_halffull(cd_fifo_halffull), .sector_done(sector_done),
    .busy(busy), .overflow(overflow)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit sb_en = 1'b0;
  logic [8:0] sb[$];

  // reference model: queue of buffered entries, an output slot, sector phase
  logic [8:0] mq[$];
  bit         m_valid, m_dm, m_half, m_ovf, m_req, m_done, m_pending;
  logic [7:0] m_dout;
  int         m_phase, m_cnt, m_len;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [14:0] act_vec();
    return {dout, dout_dm, dout_valid, cd_dat_req, cd_fifo_halffull, sector_done, busy, overflow};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {m_dout, m_dm, m_valid, m_req, m_half, m_done, (m_phase != 0), m_ovf};
  endfunction

  task automatic model_step();
    int old_lvl;
    bit old_valid, old_half;
    logic [8:0] e;
    old_lvl = mq.size();
    old_valid = m_valid;
    old_half = m_half;
    if (reset) begin
      mq.delete();
      m_valid = 0; m_dout = '0; m_dm = 0; m_half = 0; m_ovf = 0;
      m_req = 0; m_done = 0; m_phase = 0; m_pending = 0; m_cnt = 0; m_len = 0;
      return;
    end
    m_req = 0;
    m_done = 0;
    m_half = (old_lvl >= 2048);
    if (flush) begin
      mq.delete();
      m_valid = 0; m_phase = 0; m_pending = 0;
      return;
    end
    if (rd && old_valid) m_valid = 0;
    else if (!old_valid && old_lvl > 0) begin
      e = mq.pop_front();
      m_dout = e[7:0];
      m_dm = e[8];
      m_valid = 1;
    end
    if (cd_data_out_strobe) begin
      if (old_lvl < 4096) mq.push_back({cd_dm, cd_data_out});
      else m_ovf = 1;
    end
    case (m_phase)
      0: begin
        if ((sector_req || m_pending) && !old_half) begin
          m_phase = 1; m_pending = 0; m_req = 1;
        end else if (sector_req) m_pending = 1;
      end
      1: begin
        if (sector_req) m_pending = 1;
        m_phase = 2;
        m_cnt = 0;
      end
      default: begin
        if (sector_req) m_pending = 1;
        if (cd_data_out_strobe) begin
          if (m_cnt == 0) m_len = cd_dm ? 2048 : 2352;
          m_cnt++;
          if (m_cnt == m_len) begin
            m_done = 1;
            m_phase = 0;
          end
        end
      end
    endcase
  endtask

  task automatic tick();
    logic [8:0] e;
    if (sb_en && rd && dout_valid) begin
      e = (sb.size() > 0) ? sb.pop_front() : 9'bx;
      chk("pop_data", {dout_dm, dout}, e);
    end
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    chk("outputs", act_vec(), exp_vec());
    cd_data_out_strobe = 1'b0;
    flush = 1'b0;
    sector_req = 1'b0;
    rd = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input bit dm_v, input bit rd_v);
    cd_data_out = b;
    cd_dm = dm_v;
    cd_data_out_strobe = 1'b1;
    rd = rd_v;
    if (sb_en) sb.push_back({dm_v, b});
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 20000 && (m_valid || mq.size() > 0); k++) begin
      rd = dout_valid;
      tick();
    end
    tick();
    chk("drain_empty", dout_valid, 0);
    if (sb_en) chk("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic run_sector(input bit dm_v, input int n);
    int early = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        rd = $urandom_range(1);
        tick();
        if (sector_done) early++;
      end
      put(i[7:0], dm_v, $urandom_range(1));
      if (i == 2047 && !dm_v) chk("no_done_at_2048", sector_done, 0);
      if (i < n - 1 && sector_done) early++;
    end
    chk("sector_done_last", sector_done, 1);
    chk("sector_done_early", early, 0);
    tick();
    chk("sector_done_width", sector_done, 0);
    chk("idle_after_sector", busy, 0);
  endtask

  task automatic random_seg(input int cycles, input int pct);
    for (int k = 0; k < cycles; k++) begin
      cd_data_out = 8'($urandom);
      cd_dm = $urandom_range(1);
      cd_data_out_strobe = ($urandom_range(99) < pct);
      rd = $urandom_range(1);
      sector_req = ($urandom_range(39) == 0);
      flush = ($urandom_range(1499) == 0);
      reset = ($urandom_range(2999) == 0);
      tick();
      reset = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    bit got_req;
    reset = 1'b1;
    repeat (2) tick();
    chk("reset_outputs", act_vec(), 15'h0);
    reset = 1'b0;
    tick();

    // single byte latency and pop
    sb_en = 1'b1;
    cd_data_out = 8'hA5; cd_dm = 1'b1; cd_data_out_strobe = 1'b1;
    sb.push_back(9'h1A5);
    tick();
    chk("lat_n1_valid", dout_valid, 0);
    tick();
    chk("lat_n2_valid", dout_valid, 1);
    chk("lat_n2_data", dout, 8'hA5);
    rd = 1'b1;
    tick();
    chk("pop_valid_drop", dout_valid, 0);
    rd = 1'b1;
    tick();
    chk("rd_when_empty", dout_valid, 0);

    // data-mode sector
    sector_req = 1'b1;
    tick();
    chk("dat_req_pulse", cd_dat_req, 1);
    chk("busy_in_req", busy, 1);
    tick();
    chk("dat_req_one_cycle", cd_dat_req, 0);
    run_sector(1'b1, 2048);
    drain();

    // audio sector
    sector_req = 1'b1;
    tick();
    chk("dat_req_audio", cd_dat_req, 1);
    tick();
    run_sector(1'b0, 2352);
    drain();

    // half-full backpressure with a pending request
    for (int i = 0; i < 2049; i++) put(i[7:0], 1'b1, 1'b0);
    chk("hf_not_yet", cd_fifo_halffull, 0);
    tick();
    chk("hf_set", cd_fifo_halffull, 1);
    sector_req = 1'b1;
    tick();
    chk("hf_blocks_req", cd_dat_req, 0);
    repeat (3) tick();
    chk("hf_idle", busy, 0);
    rd = 1'b1;
    tick();
    got_req = 1'b0;
    for (int k = 0; k < 8 && !got_req; k++) begin
      tick();
      got_req = cd_dat_req;
    end
    chk("hf_pending_req", got_req, 1);
    chk("hf_cleared", cd_fifo_halffull, 0);
    flush = 1'b1;
    tick();
    sb.delete();
    chk("flush_valid", dout_valid, 0);
    chk("flush_busy", busy, 0);

    // overflow, head byte retained, then full drain across the pointer wrap
    for (int i = 0; i < 4100; i++) begin
      sb_en = (i < 4097);
      put(i[7:0], 1'b0, 1'b0);
    end
    sb_en = 1'b1;
    chk("ovf_set", overflow, 1);
    chk("ovf_head", {dout_dm, dout}, 9'h000);
    chk("ovf_halffull", cd_fifo_halffull, 1);
    drain();
    flush = 1'b1;
    tick();
    chk("ovf_kept_by_flush", overflow, 1);

    // flush mid-sector
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovf_cleared_by_reset", overflow, 0);
    sb_en = 1'b0;
    sector_req = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 1000; i++) put(i[7:0], 1'b1, $urandom_range(1));
    flush = 1'b1;
    cd_data_out_strobe = 1'b1;
    tick();
    chk("midflush_valid", dout_valid, 0);
    chk("midflush_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 1200; i++) begin
      put(i[7:0], 1'b1, 1'b0);
      if (sector_done) cnt++;
    end
    chk("midflush_no_done", cnt, 0);
    flush = 1'b1;
    sector_req = 1'b1;
    tick();
    tick();
    chk("flush_drops_req", cd_dat_req, 0);
    sector_req = 1'b1;
    tick();
    chk("fresh_req", cd_dat_req, 1);

    // randomized traffic against the model
    random_seg(4000, 75);
    random_seg(4000, 25);
    random_seg(4000, 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
